// File: rtl/pll_reset_seq.sv
// Lock-qualified reset sequencer and CPU clock-enable divider.
// The sequencer sits after the PLL and runs on the PLL output clock.
module pll_reset_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 1024,
  parameter int CE_DIV      = 7
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       locked,
  input  logic       cpu_wait,
  output logic       sys_rst_n,
  output logic       cpu_ce,
  output logic [7:0] lost_lock_cnt
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int CE_W   = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [CE_W-1:0]   CE_LAST   = CE_W'(CE_DIV - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   lock_s;
  logic [HOLD_W-1:0]      hold_cnt;
  logic [HOLD_W-1:0]      hold_nxt;
  logic [CE_W-1:0]        ce_cnt;
  logic [CE_W-1:0]        ce_nxt;
  logic [7:0]             lost_nxt;

  // `locked` is asynchronous to clk; only the last flop feeds the FSM.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], locked};
    end
  end

  assign lock_s = sync_ff[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= WAIT_LOCK;
      hold_cnt      <= '0;
      ce_cnt        <= '0;
      lost_lock_cnt <= 8'd0;
      sys_rst_n     <= 1'b0;
    end else begin
      state         <= state_nxt;
      hold_cnt      <= hold_nxt;
      ce_cnt        <= ce_nxt;
      lost_lock_cnt <= lost_nxt;
      sys_rst_n     <= (state_nxt == RUN);
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    lost_nxt  = lost_lock_cnt;
    ce_nxt    = '0;
    unique case (state)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = HOLD;
          hold_nxt  = '0;
        end
      end
      HOLD: begin
        // A lock drop on the terminal count still aborts the hold.
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nxt = RUN;
        end else begin
          hold_nxt = hold_cnt + HOLD_W'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          if (lost_lock_cnt != 8'hFF) begin
            lost_nxt = lost_lock_cnt + 8'd1;
          end
        end
      end
      default: begin
        state_nxt = WAIT_LOCK;
      end
    endcase

    // Divider parks on its last count while the CPU is stalled.
    if (state != RUN) begin
      ce_nxt = '0;
    end else if (ce_cnt == CE_LAST) begin
      ce_nxt = cpu_wait ? ce_cnt : '0;
    end else begin
      ce_nxt = ce_cnt + CE_W'(1);
    end
  end

  always_comb begin
    cpu_ce = (state == RUN) && (ce_cnt == CE_LAST) && !cpu_wait;
  end

endmodule

// File: doc/pll_reset_seq.md
Name: pll_reset_seq

Overview:
- Sits directly downstream of the iCE40 PLL wrapper. It consumes the PLL's asynchronous lock indication and runs on the PLL output clock (25.125 MHz).
- Produces a clean, lock-qualified system reset for the ZX Spectrum core.
- Produces the CPU clock-enable strobe: 25.125 MHz / 7 ≈ 3.589 MHz.
- Tracks loss-of-lock events for debug.

Parameters:
- SYNC_STAGES, 2: synchronizer depth for `locked`. Must be ≥2.
- HOLD_CYCLES, 1024: consecutive cycles of synchronized lock required before releasing reset. Must be ≥1.
- CE_DIV, 7: CPU clock-enable divide ratio. Must be ≥1.

Ports:
- clk  in  1: system clock (PLL output).
- resetn  in  1: asynchronous active-low reset.
- locked  in  1: PLL lock, asynchronous to clk.
- cpu_wait  in  1: suppresses CPU enable pulses while high.
- sys_rst_n  out  1: active-low synchronous-release reset for the core.
- cpu_ce  out  1: single-cycle CPU clock enable.
- lost_lock_cnt  out  8: saturating count of lock losses seen while in RUN.

Behaviour:
- Reset (resetn low, asynchronous, immediate):
  - Synchronizer flops = 0.
  - state = WAIT_LOCK.
  - hold_cnt = 0, ce_cnt = 0.
  - sys_rst_n = 0, lost_lock_cnt = 0.
  - cpu_ce = 0.
- Synchronizer: `locked` passes through SYNC_STAGES flops; the last flop is lock_s. No other logic uses `locked` directly.
- State machine (registered, one transition per edge):
  - WAIT_LOCK: if lock_s=1, go to HOLD and clear hold_cnt to 0.
  - HOLD:
    - If lock_s=0, go to WAIT_LOCK. hold_cnt is discarded and lost_lock_cnt is unchanged.
    - Else, if hold_cnt == HOLD_CYCLES-1, go to RUN.
    - Else, increment hold_cnt.
  - RUN:
    - If lock_s=0, go to WAIT_LOCK and increment lost_lock_cnt, saturating at 255.
    - Otherwise stay in RUN.
- sys_rst_n:
  - Registered; equals 1 exactly while state == RUN.
  - Rises on the edge that enters RUN; falls on the edge that leaves RUN.
  - Release latency, measured from `locked` rising just before edge 1: lock_s=1 after edge SYNC_STAGES, HOLD entered at edge SYNC_STAGES+1, sys_rst_n=1 after edge SYNC_STAGES+1+HOLD_CYCLES.
- ce_cnt (width clog2(CE_DIV), minimum 1 bit):
  - Cleared to 0 in every cycle with state != RUN.
  - In RUN it counts 0..CE_DIV-1.
  - At CE_DIV-1: if cpu_wait=0, wraps to 0; if cpu_wait=1, holds at CE_DIV-1.
- cpu_ce:
  - Combinational decode: (state==RUN) & (ce_cnt==CE_DIV-1) & !cpu_wait.
  - The same-cycle path from cpu_wait to cpu_ce is intentional.
  - The first pulse occurs in the CE_DIV-th cycle of RUN.
  - If cpu_wait is held high at wrap, there are no pulses; a pulse occurs in the first cycle cpu_wait is low, then pulses resume every CE_DIV cycles.
  - CE_DIV=1: cpu_ce = !cpu_wait throughout RUN.
- Lock loss in RUN: sys_rst_n and cpu_ce go to 0 together, at the edge leaving RUN. Re-entry requires a full HOLD period.
- Simultaneous lock_s=0 and hold_cnt terminal in HOLD: lock loss wins; go to WAIT_LOCK.
- resetn asserted mid-RUN: all outputs return to reset values asynchronously, including lost_lock_cnt = 0.
- resetn released while `locked` is already high: the normal synchronizer plus HOLD latency applies; there is no shortcut.

Test Plan:
1. SYNC_STAGES=2, HOLD_CYCLES=8, CE_DIV=7; release resetn, raise `locked` before edge 1 -> sys_rst_n=1 after edge 11; first cpu_ce in cycle 7 of RUN, then every 7 cycles.
2. Same configuration; drop `locked` for 3 cycles while hold_cnt=5 -> return to WAIT_LOCK; after relock, a full 8-cycle HOLD; sys_rst_n stays 0 throughout; lost_lock_cnt stays 0.
3. In RUN, drop `locked` -> sys_rst_n=0 and cpu_ce=0 after edge 3 (2 sync + 1); lost_lock_cnt=1; relock -> sys_rst_n=1 again 11 edges after `locked` rises.
4. In RUN, hold cpu_wait=1 for 10 cycles spanning a wrap -> no cpu_ce while high; cpu_ce=1 in the first cycle cpu_wait=0; next pulse 7 cycles later. CE_DIV=1 build: cpu_ce tracks !cpu_wait.
5. Assert resetn low asynchronously mid-RUN, between clock edges -> sys_rst_n, cpu_ce, and lost_lock_cnt read 0 immediately; after release, the full WAIT_LOCK/HOLD sequence is required.
6. Toggle `locked` through 260 RUN->lose cycles (HOLD_CYCLES=1) -> lost_lock_cnt saturates at 255 and does not wrap.
